// File: rtl/la_pkg.sv
// Shared types and constants for the trigger-driven logic analyzer capture block.
package la_pkg;

    localparam int unsigned DefDataW = 256;
    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefTsW   = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPre   = 3'd1,
        StArmed = 3'd2,
        StPost  = 3'd3,
        StDone  = 3'd4
    } la_state_e;

    function automatic int unsigned la_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/la_ring_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module la_ring_mem
    import la_pkg::*;
#(
    parameter int unsigned WIDTH  = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [WIDTH-1:0]  dina,
    input  logic [ADDR_W-1:0] addrb,
    output logic [WIDTH-1:0]  doutb
);

    localparam int unsigned DEPTH = la_depth(ADDR_W);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wea) begin
            mem[addra] <= dina;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutb <= '0;
        end else begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/la_trig_capture.sv
// Trigger-driven logic analyzer capture with pre/post-trigger windows in a ring buffer.
// Define LA_TIMESTAMP_EN to store a free-running cycle timestamp with every sample.
module la_trig_capture
    import la_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned TS_W   = DefTsW,
`ifdef LA_TIMESTAMP_EN
    localparam int unsigned SAMP_W = DATA_W + TS_W
`else
    localparam int unsigned SAMP_W = DATA_W
`endif
) (
    input  logic              clk,
    input  logic              la_rst_n,
    input  logic              arm,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] probe,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [SAMP_W-1:0] rd_data,
    output logic [2:0]        state_o,
    output logic              done,
    output logic              trig_seen
);

    localparam logic [ADDR_W-1:0] PtrMax = ADDR_W'(la_depth(ADDR_W) - 1);

    la_state_e         state_q;
    logic [ADDR_W-1:0] wr_ptr_q, pre_q, cnt_q, post_q, trig_ptr_q;
    logic              done_q, trig_seen_q;

    logic              arm_go, wr_en, trig_hit;
    logic [SAMP_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_phys;

    assign arm_go   = arm && (state_q == StIdle || state_q == StDone);
    // pre_q == 0 skips straight to ARMED without storing the PRE-cycle sample
    assign wr_en    = sample_en && ((state_q == StPre && pre_q != '0) ||
                                    state_q == StArmed || state_q == StPost);
    assign trig_hit = sample_en && (((probe ^ trig_value) & trig_mask) == '0);
    assign rd_phys  = trig_ptr_q - pre_q + rd_addr;

    always_ff @(posedge clk or negedge la_rst_n) begin
        if (!la_rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            pre_q       <= '0;
            cnt_q       <= '0;
            post_q      <= '0;
            trig_ptr_q  <= '0;
            done_q      <= 1'b0;
            trig_seen_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        state_q     <= StPre;
                        pre_q       <= pre_count;
                        cnt_q       <= '0;
                        post_q      <= '0;
                        wr_ptr_q    <= '0;
                        done_q      <= 1'b0;
                        trig_seen_q <= 1'b0;
                    end
                end
                StPre: begin
                    if (pre_q == '0) begin
                        state_q <= StArmed;
                    end else if (sample_en) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (ADDR_W'(cnt_q + 1'b1) == pre_q) begin
                            state_q <= StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (trig_hit) begin
                        trig_ptr_q  <= wr_ptr_q;
                        trig_seen_q <= 1'b1;
                        post_q      <= PtrMax - pre_q;
                        if (pre_q == PtrMax) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StPost;
                        end
                    end
                end
                StPost: begin
                    if (sample_en) begin
                        post_q <= post_q - 1'b1;
                        if (post_q == ADDR_W'(1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LA_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge la_rst_n) begin
        if (!la_rst_n) begin
            ts_q <= '0;
        end else if (arm_go) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wr_data = {ts_q, probe};
`else
    assign wr_data = probe;
`endif

    la_ring_mem #(
        .WIDTH  (SAMP_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (la_rst_n),
        .wea   (wr_en),
        .addra (wr_ptr_q),
        .dina  (wr_data),
        .addrb (rd_phys),
        .doutb (rd_data)
    );

    assign state_o   = state_q;
    assign done      = done_q;
    assign trig_seen = trig_seen_q;

endmodule

// File: tb/tb_la_trig_capture.sv
// Randomised bench for la_trig_capture against a sample-queue reference model.
module tb_la_trig_capture;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int TW    = 16;
    localparam int DEPTH = 16;
`ifdef LA_TIMESTAMP_EN
    localparam int SW = DW + TW;
`else
    localparam int SW = DW;
`endif

    logic          clk, la_rst_n, arm, sample_en;
    logic [DW-1:0] probe, trig_mask, trig_value;
    logic [AW-1:0] pre_count, rd_addr;
    logic [SW-1:0] rd_data;
    logic [2:0]    state_o;
    logic          done, trig_seen;

    la_trig_capture #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TS_W   (TW)
    ) dut (
        .clk        (clk),
        .la_rst_n   (la_rst_n),
        .arm        (arm),
        .sample_en  (sample_en),
        .probe      (probe),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .pre_count  (pre_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .state_o    (state_o),
        .done       (done),
        .trig_seen  (trig_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 pre, 2 armed, 3 post, 4 done; wq holds every stored sample
    int            m_phase, m_pre, m_cnt, m_left;
    bit            m_seen;
    logic [TW-1:0] m_ts;
    logic [SW-1:0] wq[$];
    int            pc;

    task automatic model_reset();
        m_phase = 0; m_pre = 0; m_cnt = 0; m_left = 0; m_seen = 0; m_ts = '0;
    endtask

    task automatic model_step();
        bit            go = 0;
        logic [SW-1:0] s;
`ifdef LA_TIMESTAMP_EN
        s = {m_ts, probe};
`else
        s = probe;
`endif
        case (m_phase)
            0, 4: if (arm) begin
                go = 1; m_phase = 1; m_pre = int'(pre_count); m_cnt = 0; m_seen = 0;
                wq.delete();
            end
            1: if (m_pre == 0) m_phase = 2;
               else if (sample_en) begin
                   wq.push_back(s); m_cnt++;
                   if (m_cnt == m_pre) m_phase = 2;
               end
            2: if (sample_en) begin
                   wq.push_back(s);
                   if ((probe & trig_mask) == (trig_value & trig_mask)) begin
                       m_seen = 1; m_left = DEPTH - 1 - m_pre;
                       m_phase = (m_left == 0) ? 4 : 3;
                   end
               end
            3: if (sample_en) begin
                   wq.push_back(s); m_left--;
                   if (m_left == 0) m_phase = 4;
               end
            default: ;
        endcase
        if (go) m_ts = '0;
        else m_ts = m_ts + 1'b1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("state_o", 64'(state_o), 64'(m_phase));
        check("done", 64'(done), 64'(m_phase == 4));
        check("trig_seen", 64'(trig_seen), 64'(m_seen));
        @(negedge clk);
    endtask

    // mode 0: counting probe, always qualified; 1: random probe, toggling qualifier;
    // 2: random probe and qualifier with stray arm pulses
    task automatic drive(input int mode);
        case (mode)
            0: begin probe = DW'(pc); sample_en = 1'b1; end
            1: begin probe = DW'($urandom); sample_en = ~sample_en; end
            default: begin
                probe = DW'($urandom); sample_en = ($urandom_range(0, 3) != 0);
                arm = ($urandom_range(0, 7) == 0);
            end
        endcase
        pc++;
    endtask

    task automatic start(input int pre, input logic [DW-1:0] mask, input logic [DW-1:0] val,
                         input int mode);
        pre_count = AW'(pre); trig_mask = mask; trig_value = val;
        pc = 0;
        drive(mode);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic run_to_done(input int mode);
        int budget = 1000;
        while (!done && budget > 0) begin
            drive(mode);
            tick();
            budget--;
        end
        arm = 1'b0;
        check("capture_done", 64'(done), 64'(1));
    endtask

    task automatic readout(input bit basic);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            sample_en = 1'b0;
            tick();
            check("rd_data", 64'(rd_data), 64'(wq[wq.size() - DEPTH + i]));
            if (basic) check("basic_rd", 64'(rd_data[DW-1:0]), 64'(8'h26 + i));
        end
    endtask

    initial begin
        arm = 0; sample_en = 0; probe = '0; trig_mask = '0; trig_value = '0;
        pre_count = '0; rd_addr = '0; pc = 0;
        la_rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 64'(state_o), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_trig_seen", 64'(trig_seen), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        la_rst_n = 1'b1;
        tick();

        // Basic: trigger on 0x2A with 4 pre-trigger samples
        start(4, 8'hFF, 8'h2A, 0);
        run_to_done(0);
        check("basic_last", 64'(pc - 1), 64'(8'h2A + 11));
        readout(1'b1);

        // Zero pre-trigger window, mask 0: trigger sample lands at index 0
        start(0, 8'h00, 8'h00, 1);
        run_to_done(1);
        readout(1'b0);

        // Wrap: long ARMED phase before trigger at 0x30
        start(4, 8'hFF, 8'h30, 0);
        run_to_done(0);
        readout(1'b0);

        // Full pre-trigger window: trigger sample ends the capture
        start(DEPTH - 1, 8'h03, DW'($urandom), 1);
        run_to_done(1);
        readout(1'b0);

        // Randomised captures with stray arm pulses, re-armed from DONE
        for (int r = 0; r < 8; r++) begin
            start($urandom_range(0, DEPTH - 1), 8'h03, DW'($urandom), 2);
            run_to_done(2);
            readout(1'b0);
        end

        // Asynchronous reset during POST
        start(2, 8'hFF, 8'h0A, 0);
        for (int i = 0; i < 100 && m_phase != 3; i++) begin
            drive(0);
            tick();
        end
        check("reached_post", 64'(state_o), 64'(3));
        la_rst_n = 1'b0;
        #1;
        model_reset();
        check("async_state", 64'(state_o), 64'(0));
        check("async_done", 64'(done), 64'(0));
        check("async_trig_seen", 64'(trig_seen), 64'(0));
        tick();
        la_rst_n = 1'b1;
        start(1, 8'hFF, 8'h05, 0);
        run_to_done(0);
        readout(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/la_trig_capture.md
Name: la_trig_capture

Overview:
- Parametrised, trigger-driven successor to the free-running logic analyzer capture.
- Samples a wide probe bus into a circular buffer while armed and holds a configurable number of pre-trigger samples.
- On a mask/value trigger match, captures the remaining post-trigger samples, then freezes for software readout.
- Sits beside the datapath; software drives arm and reads back through a logical-index read port.

Parameters:
DATA_W, 256, probe/sample width in bits
ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W samples
TS_W, 16, timestamp width (used only with LA_TIMESTAMP_EN)

Ports:
clk  in  1  capture and read clock
la_rst_n  in  1  asynchronous active-low reset
arm  in  1  1-cycle pulse; starts a new capture from IDLE or DONE
sample_en  in  1  sample qualifier; probe is written only when high
probe  in  DATA_W  sampled bus
trig_mask  in  DATA_W  trigger bit mask; 1 = bit compared
trig_value  in  DATA_W  trigger compare value
pre_count  in  ADDR_W  pre-trigger samples to retain; latched on arm
rd_addr  in  ADDR_W  logical read index; 0 = oldest sample
rd_data  out  SAMP_W  sample at rd_addr, 1-cycle latency (SAMP_W = DATA_W, or DATA_W+TS_W with feature)
state_o  out  3  FSM state encoding
done  out  1  high while in DONE
trig_seen  out  1  trigger has occurred in the current capture

Behaviour:
- Reset: FSM=IDLE, wr_ptr=0, counters=0, done=0, trig_seen=0, rd_data=0; buffer contents undefined.
- FSM encoding: IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
- IDLE/DONE + arm → PRE. On that edge: latch pre_q=pre_count, clear counters and trig_seen, wr_ptr=0. arm is ignored in PRE, ARMED and POST.
- Write rule: in PRE, ARMED and POST, a cycle with sample_en=1 writes probe at wr_ptr; wr_ptr increments mod DEPTH and wraps silently.
- PRE: count qualified writes. When count reaches pre_q → ARMED. pre_q=0 → ARMED on the cycle after arm. The trigger is not evaluated in PRE.
- ARMED: trigger = sample_en & ((probe & trig_mask) == (trig_value & trig_mask)).
  - On trigger: that sample is written; trig_ptr=wr_ptr; trig_seen=1; post_left = DEPTH-1-pre_q; → POST, or → DONE directly if post_left=0.
  - trig_mask=0 triggers on the first qualified sample.
- POST: each qualified write decrements post_left. The write that makes it 0 → DONE. Stops after exactly DEPTH samples in total.
- DONE: no writes; done=1 until the next arm.
- Readout: physical address = (trig_ptr - pre_q + rd_addr) mod DEPTH.
  - rd_data is registered one cycle after rd_addr and valid in any state.
  - Contents are only meaningful in DONE.
  - The trigger sample is at logical index pre_q.
- Simultaneous arm and trigger in IDLE: arm wins; the trigger is not evaluated.
- Async reset mid-capture: immediate return to IDLE; done=0.

Optional Feature:
- Macro LA_TIMESTAMP_EN.
- Defined:
  - A TS_W-bit free-running cycle counter, cleared on arm and wrapping.
  - Stored with each sample; rd_data = {timestamp, sample}, width DATA_W+TS_W.
- Undefined: no counter; rd_data width DATA_W.

Decomposition:
- Package la_pkg holds:
  - FSM state enum (3-bit) and state_o encodings
  - DEPTH derivation helper
  - default parameter constants
- One sub-module: la_ring_mem.
  - Simple dual-port RAM with write port (wea, addra, dina) and registered read port (addrb, doutb).
  - Parametrised by width and ADDR_W; inferable as block RAM.

Test Plan:
- Basic capture. ADDR_W=4, pre_count=4, mask=0xFF, value=0x2A; probe counts 0,1,2… with sample_en=1 → done after sample 0x2A+11. rd_addr 0..15 returns 0x26..0x35. trig_seen=1.
- pre_count=0, mask=0 → trigger on the first sample after arm. rd_addr 0 holds the trigger sample. 16 samples captured.
- Qualifier gating. sample_en toggles 1/0 → only qualified samples stored. Read order is contiguous, with no duplicates.
- Wrap. ADDR_W=4, pre_count=4; trigger after 40 cycles in ARMED → logical 0..3 = the 4 samples before the trigger. Correct mod-16 address arithmetic.
- Reset and re-arm.
  - la_rst_n low during POST → state_o=0, done=0 immediately (asynchronous).
  - arm during POST is ignored.
  - arm in DONE restarts the capture with trig_seen cleared.
- LA_TIMESTAMP_EN defined; sample_en every 3rd cycle → stored timestamps differ by 3. First timestamp = cycles since arm.
